dmem_arbiter: RTL and testbench

//  Arbitrates and sequences the single-port 256x8 data RAM between two requesters:

---
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-RAM arbiter, its two requesters and the RAM.
// slave = arbiter view, master = requesters/RAM environment view.
interface dmem_arbiter_if;
   logic       p_req;
   logic       p_we;
   logic [7:0] p_addr;
   logic [7:0] p_wdata;
   logic [7:0] p_rdata;
   logic       p_odv;
   logic       x_hs_in;
   logic       x_we;
   logic [7:0] x_addr;
   logic [7:0] x_wdata;
   logic [7:0] x_rdata;
   logic       x_hs_out;
   logic [7:0] m_addr;
   logic       m_rd;
   logic       m_wr;
   logic [7:0] m_wdata;
   logic [7:0] m_rdata;
   logic       x_forced;

   modport slave (
      input  p_req, p_we, p_addr, p_wdata, x_hs_in, x_we, x_addr, x_wdata, m_rdata,
      output p_rdata, p_odv, x_rdata, x_hs_out, m_addr, m_rd, m_wr, m_wdata, x_forced
   );

   modport master (
      output p_req, p_we, p_addr, p_wdata, x_hs_in, x_we, x_addr, x_wdata, m_rdata,
      input  p_rdata, p_odv, x_rdata, x_hs_out, m_addr, m_rd, m_wr, m_wdata, x_forced
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: pipeline stage three (priority) versus the
// asynchronous 4-phase external port, with a starvation override for the latter.
module dmem_arbiter #(
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned STARVE_MAX  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic           g_clk,
   input  logic           g_clr,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, P_ACC, P_WAIT, P_DONE, X_ACC, X_WAIT, X_DONE} state_t;

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
   localparam logic [7:0] CNT_MAX  = 8'(STARVE_MAX);

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] x_sync;
   logic                   xs;
   logic [7:0]             starve_cnt;
   logic [1:0]             lat_cnt;
   logic                   lat_last;
   logic                   op_we;
   logic                   x_wd;
   logic                   x_keep;
   logic                   x_active;
   logic                   grant_p, grant_x, forced;

   assign xs       = x_sync[SYNC_STAGES-1];
   assign lat_last = (lat_cnt == LAT_LAST);
   // A withdrawal seen at any point of the X access suppresses the acknowledge.
   assign x_keep   = xs && !x_wd;
   assign x_active = (state == X_ACC) || (state == X_WAIT) || (state == X_DONE);
   assign bus.p_odv = !bus.p_req || (state == P_DONE);

   always_comb begin
      state_nxt = state;
      grant_p   = 1'b0;
      grant_x   = 1'b0;
      forced    = 1'b0;
      case (state)
         IDLE: begin
            if (xs && (!bus.p_req || starve_cnt == CNT_MAX)) begin
               grant_x   = 1'b1;
               forced    = bus.p_req;
               state_nxt = X_ACC;
            end else if (bus.p_req) begin
               grant_p   = 1'b1;
               state_nxt = P_ACC;
            end
         end
         P_ACC:  state_nxt = op_we ? P_DONE : P_WAIT;
         P_WAIT: if (lat_last) state_nxt = P_DONE;
         P_DONE: state_nxt = IDLE;
         X_ACC: begin
            if (op_we) state_nxt = x_keep ? X_DONE : IDLE;
            else       state_nxt = X_WAIT;
         end
         X_WAIT: if (lat_last) state_nxt = x_keep ? X_DONE : IDLE;
         X_DONE: if (!xs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         state        <= IDLE;
         x_sync       <= '0;
         starve_cnt   <= '0;
         lat_cnt      <= '0;
         op_we        <= 1'b0;
         x_wd         <= 1'b0;
         bus.m_addr   <= '0;
         bus.m_rd     <= 1'b0;
         bus.m_wr     <= 1'b0;
         bus.m_wdata  <= '0;
         bus.p_rdata  <= '0;
         bus.x_rdata  <= '0;
         bus.x_hs_out <= 1'b0;
         bus.x_forced <= 1'b0;
      end else begin
         state        <= state_nxt;
         x_sync       <= {x_sync[SYNC_STAGES-2:0], bus.x_hs_in};
         bus.m_rd     <= 1'b0;
         bus.m_wr     <= 1'b0;
         bus.x_forced <= forced;
         bus.x_hs_out <= (state_nxt == X_DONE);

         if (grant_x || !xs)
            starve_cnt <= '0;
         else if (!x_active && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 8'd1;

         if (grant_x)
            x_wd <= 1'b0;
         else if ((state == X_ACC || state == X_WAIT) && !xs)
            x_wd <= 1'b1;

         if (state == P_WAIT || state == X_WAIT) lat_cnt <= lat_cnt + 2'd1;
         else                                    lat_cnt <= '0;

         // Strobes are launched on the grant edge so they are live in the *_ACC cycle.
         if (grant_p) begin
            op_we      <= bus.p_we;
            bus.m_addr <= bus.p_addr;
            bus.m_wr   <= bus.p_we;
            bus.m_rd   <= !bus.p_we;
            if (bus.p_we) bus.m_wdata <= bus.p_wdata;
         end
         if (grant_x) begin
            op_we      <= bus.x_we;
            bus.m_addr <= bus.x_addr;
            bus.m_wr   <= bus.x_we;
            bus.m_rd   <= !bus.x_we;
            if (bus.x_we) bus.m_wdata <= bus.x_wdata;
         end

         if (state == P_WAIT && lat_last) bus.p_rdata <= bus.m_rdata;
         if (state == X_WAIT && lat_last) bus.x_rdata <= bus.m_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: behavioural RAM, reference memory model,
// read-data queues popped by a monitor, plus directed arbitration scenarios.
module tb_dmem_arbiter;
   localparam int unsigned RD_LAT      = 1;
   localparam int unsigned STARVE_MAX  = 8;
   localparam int unsigned SYNC_STAGES = 2;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   dmem_arbiter_if bus();

   dmem_arbiter #(
      .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .g_clk(clk), .g_clr(clr), .bus(bus)
   );

   // Behavioural single-port RAM with RD_LAT read latency.
   logic [7:0] ram     [256];
   logic [7:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      if (bus.m_wr) ram[bus.m_addr] <= bus.m_wdata;
      if (bus.m_rd) rd_pipe[0] <= ram[bus.m_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.m_rdata = rd_pipe[RD_LAT-1];

   logic [7:0] ref_mem [256];
   logic [7:0] p_q[$];
   logic [7:0] x_q[$];
   logic [8:0] strobe_log[$];
   int         forced_log[$];
   int n_tests = 0, n_fail = 0;
   int cyc = 0, x_drive_cyc = 0, p_drive_cyc = 0, last_strobe_cyc = 0, x_rise_cnt = 0;
   bit in_x = 1'b0, podv_in_x = 1'b0;
   logic xo_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int count_addr(input logic [7:0] a);
      int n = 0;
      foreach (strobe_log[i]) if (strobe_log[i][7:0] == a) n++;
      return n;
   endfunction

   // Monitor: samples one time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (clr) begin
         in_x = 1'b0;
      end else begin
         if (bus.m_rd || bus.m_wr) begin
            chk("strobe_excl", int'(bus.m_rd & bus.m_wr), 0);
            strobe_log.push_back({bus.m_wr, bus.m_addr});
            last_strobe_cyc = cyc;
         end
         if (bus.x_forced) begin
            forced_log.push_back(cyc);
            in_x = 1'b1;
         end
         if (in_x && bus.p_req && bus.p_odv) podv_in_x = 1'b1;
         if (xo_prev && !bus.x_hs_out) in_x = 1'b0;
         if (bus.p_req && bus.p_odv && !bus.p_we) begin
            chk("p_q_nonempty", int'(p_q.size() != 0), 1);
            if (p_q.size() != 0) chk("p_rdata", bus.p_rdata, p_q.pop_front());
         end
         if (bus.x_hs_out && !xo_prev) begin
            x_rise_cnt++;
            if (!bus.x_we) begin
               chk("x_q_nonempty", int'(x_q.size() != 0), 1);
               if (x_q.size() != 0) chk("x_rdata", bus.x_rdata, x_q.pop_front());
            end
         end
      end
      xo_prev = bus.x_hs_out;
   end

   task automatic p_access(input logic we, input logic [7:0] a, input logic [7:0] d, input bit lat);
      int n;
      @(negedge clk);
      bus.p_req = 1'b1; bus.p_we = we; bus.p_addr = a; bus.p_wdata = d;
      p_drive_cyc = cyc;
      if (we) ref_mem[a] = d; else p_q.push_back(ref_mem[a]);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.p_odv && n < 100);
      if (lat) chk(we ? "p_wr_latency" : "p_rd_latency", n, we ? 2 : 2 + int'(RD_LAT));
      else     chk("p_done_in_time", int'(n < 100), 1);
      @(negedge clk);
      bus.p_req = 1'b0;
   endtask

   task automatic p_stream(input int count);
      int n;
      logic [7:0] d;
      @(negedge clk);
      bus.p_req = 1'b1;
      for (int i = 0; i < count; i++) begin
         d = 8'($urandom);
         bus.p_we = 1'b1; bus.p_addr = 8'(8'h80 + i); bus.p_wdata = d;
         ref_mem[8'(8'h80 + i)] = d;
         n = 0;
         do begin @(posedge clk); #1; n++; end while (!bus.p_odv && n < 100);
         chk("p_stream_done", int'(n < 100), 1);
         @(negedge clk);
      end
      bus.p_req = 1'b0;
   endtask

   task automatic x_access(input logic we, input logic [7:0] a, input logic [7:0] d, input bit lat);
      int n, base;
      @(negedge clk);
      bus.x_we = we; bus.x_addr = a; bus.x_wdata = d; bus.x_hs_in = 1'b1;
      x_drive_cyc = cyc;
      if (we) ref_mem[a] = d; else x_q.push_back(ref_mem[a]);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.x_hs_out && n < 100);
      base = int'(SYNC_STAGES) + 2 + (we ? 0 : int'(RD_LAT));
      if (lat) chk("x_rise_latency_ok", int'(n >= base && n <= base + 1), 1);
      else     chk("x_ack_in_time", int'(n < 100), 1);
      @(negedge clk);
      bus.x_hs_in = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (bus.x_hs_out && n < 100);
      chk("x_fall_latency", n, int'(SYNC_STAGES) + 1);
   endtask

   task automatic chk_forced_window(input string nm);
      int lo, hi, d;
      lo = int'(SYNC_STAGES + STARVE_MAX) + 1;
      hi = lo + 2;
      chk({nm, "_forced_once"}, forced_log.size(), 1);
      if (forced_log.size() != 0) begin
         d = forced_log[0] - x_drive_cyc;
         chk({nm, "_forced_window"}, int'(d >= lo && d <= hi), 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   initial begin
      int rise0;
      logic we;
      logic [7:0] a, d;
      bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
      bus.x_hs_in = 0; bus.x_we = 0; bus.x_addr = '0; bus.x_wdata = '0;
      clr = 1'b1;
      repeat (3) @(negedge clk);
      bus.p_req = 1'b1;
      @(posedge clk); #1;
      chk("rst_p_odv_req", bus.p_odv, 0);
      chk("rst_strobes", {bus.m_rd, bus.m_wr, bus.x_hs_out, bus.x_forced}, 0);
      chk("rst_data", {bus.p_rdata, bus.x_rdata, bus.m_addr, bus.m_wdata}, 0);
      @(negedge clk);
      bus.p_req = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
      chk("idle_p_odv", bus.p_odv, 1);

      // P write then read back
      strobe_log.delete();
      p_access(1'b1, 8'h10, 8'h5A, 1'b1);
      chk("t1_strobe_count", strobe_log.size(), 1);
      if (strobe_log.size() != 0) chk("t1_strobe", strobe_log[0], {1'b1, 8'h10});
      chk("t1_wr_cycle", last_strobe_cyc - p_drive_cyc, 1);
      p_access(1'b0, 8'h10, 8'h00, 1'b1);
      chk("t1_rdata_held", bus.p_rdata, 8'h5A);

      for (int i = 0; i < 16; i++) p_access(1'b1, 8'(i), 8'($urandom), 1'b1);

      // X read over the handshake
      x_access(1'b0, 8'h10, 8'h00, 1'b1);

      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom_range(0, 1));
         a  = 8'($urandom_range(0, 15));
         d  = 8'($urandom);
         if ($urandom_range(0, 1) == 1) p_access(we, a, d, 1'b1);
         else                           x_access(we, a, d, 1'b1);
      end

      // P and X arrive in the same IDLE cycle
      strobe_log.delete();
      fork
         x_access(1'b0, 8'd6, 8'h00, 1'b0);
         begin
            repeat (SYNC_STAGES) @(negedge clk);
            p_access(1'b1, 8'd5, 8'hC3, 1'b1);
         end
      join
      chk("t3_strobe_count", strobe_log.size(), 2);
      if (strobe_log.size() == 2) begin
         chk("t3_first_p", strobe_log[0], {1'b1, 8'd5});
         chk("t3_second_x", strobe_log[1], {1'b0, 8'd6});
      end

      // Starvation override under continuous P load
      strobe_log.delete(); forced_log.delete(); podv_in_x = 1'b0;
      fork
         p_stream(12);
         begin
            repeat (2) @(negedge clk);
            x_access(1'b0, 8'd7, 8'h00, 1'b0);
         end
      join
      chk_forced_window("t4");
      chk("t4_p_odv_low_during_x", podv_in_x, 0);
      chk("t4_x_strobe", count_addr(8'd7), 1);
      chk("t4_strobe_count", strobe_log.size(), 13);

      // X withdraws before grant, then must wait the full starvation period again
      strobe_log.delete(); forced_log.delete();
      rise0 = x_rise_cnt;
      fork
         p_stream(20);
         begin
            repeat (2) @(negedge clk);
            bus.x_we = 1'b0; bus.x_addr = 8'd9; bus.x_hs_in = 1'b1;
            repeat (SYNC_STAGES + 3) @(negedge clk);
            bus.x_hs_in = 1'b0;
            repeat (SYNC_STAGES + 2) @(negedge clk);
            chk("t5_no_x_strobe", count_addr(8'd9), 0);
            chk("t5_no_ack", x_rise_cnt - rise0, 0);
            chk("t5_no_forced", forced_log.size(), 0);
            x_access(1'b0, 8'd9, 8'h00, 1'b0);
            chk_forced_window("t5");
         end
      join

      // p_req dropped during P_ACC: the write still lands
      strobe_log.delete();
      @(negedge clk);
      bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 8'h20; bus.p_wdata = 8'h3C;
      ref_mem[8'h20] = 8'h3C;
      @(negedge clk);
      bus.p_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("drop_write_strobe", count_addr(8'h20), 1);
      x_access(1'b0, 8'h20, 8'h00, 1'b1);

      // Reset during P_WAIT
      @(negedge clk);
      bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 8'd3;
      repeat (2) @(negedge clk);
      clr = 1'b1; bus.p_req = 1'b0;
      @(posedge clk); #1;
      chk("t6p_strobes", {bus.m_rd, bus.m_wr, bus.x_hs_out}, 0);
      chk("t6p_p_odv", bus.p_odv, 1);
      chk("t6p_p_rdata", bus.p_rdata, 0);
      @(negedge clk);
      clr = 1'b0;

      // Reset during X_DONE
      @(negedge clk);
      bus.x_we = 1'b0; bus.x_addr = 8'd4; bus.x_hs_in = 1'b1;
      x_q.push_back(ref_mem[8'd4]);
      for (int n = 0; n < 100 && !bus.x_hs_out; n++) begin @(posedge clk); #1; end
      chk("t6x_reached_done", bus.x_hs_out, 1);
      @(negedge clk);
      clr = 1'b1; bus.x_hs_in = 1'b0;
      @(posedge clk); #1;
      chk("t6x_hs_out", bus.x_hs_out, 0);
      chk("t6x_strobes", {bus.m_rd, bus.m_wr}, 0);
      repeat (SYNC_STAGES + 1) @(negedge clk);
      clr = 1'b0;
      x_access(1'b0, 8'd4, 8'h00, 1'b1);
      p_access(1'b0, 8'd4, 8'h00, 1'b1);

      repeat (4) @(negedge clk);
      chk("p_q_drained", p_q.size(), 0);
      chk("x_q_drained", x_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
